uart_rx_packet_decoder: RTL

- Receive-side framing decoder; the decoding end of the byte-packet protocol the transmit path sends over the UART link.
- Consumes the byte strobes from the UART receiver (data, valid, framing and parity error flags).
- Hunts for a start byte, checks length and XOR checksum, and buffers the payload.
- Releases verified payloads downstream over a valid/ready byte stream with an end-of-packet marker.

---
 rtl/uart_pkt_pkg.sv | 15 +
 rtl/uart_pkt_buf.sv | 31 +++
 rtl/uart_rx_packet_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// rtl/uart_pkt_pkg.sv - shared framing definitions for the UART byte-packet link
package uart_pkt_pkg;

    localparam int         LEN_W        = 8;
    localparam logic [7:0] DEF_SOF_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_PAYLOAD,
        S_CHK,
        S_DRAIN
    } state_t;

endpackage

// File: rtl/uart_pkt_buf.sv
// rtl/uart_pkt_buf.sv - payload register file, one write port, one registered read port
module uart_pkt_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_rdata <= 8'h00;
        end else begin
            o_rdata <= r_mem[i_raddr];
        end
    end

endmodule

// File: rtl/uart_rx_packet_decoder.sv
// rtl/uart_rx_packet_decoder.sv - SOF/LEN/payload/CHK frame decoder with buffered drain
// Optional inter-byte timeout enabled by defining RX_TIMEOUT_EN.
module uart_rx_packet_decoder
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE       = DEF_SOF_BYTE,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_ferror,
    input  logic       rx_perror,
    output logic [7:0] out_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic [7:0] pkt_len,
    output logic       busy,
    output logic       err_chk,
    output logic       err_len,
    output logic       err_line,
    output logic       overrun
);

    localparam int AW = $clog2(MAX_LEN);

    state_t           r_state, w_state_next;
    logic [LEN_W-1:0] r_len, r_chk, r_pkt_len;
    logic [AW-1:0]    r_idx, r_rd, w_rd_next;
    logic             w_line_err, w_in_frame, w_xfer, w_rd_last, w_idx_last, w_timeout;
    logic             w_we, w_err_chk, w_err_len, w_err_line, w_overrun;
    logic [7:0]       w_rdata;

    assign w_line_err = rx_valid & (rx_ferror | rx_perror);
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_PAYLOAD) || (r_state == S_CHK);
    assign w_xfer     = (r_state == S_DRAIN) && out_ready;
    assign w_rd_last  = LEN_W'(r_rd) == (r_len - LEN_W'(1));
    assign w_idx_last = LEN_W'(r_idx) == (r_len - LEN_W'(1));

`ifdef RX_TIMEOUT_EN
    logic [31:0] r_tcnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= 32'd0;
        end else if (rx_valid || !w_in_frame) begin
            r_tcnt <= 32'd0;
        end else begin
            r_tcnt <= r_tcnt + 32'd1;
        end
    end

    assign w_timeout = w_in_frame && !rx_valid && (r_tcnt == 32'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TIMEOUT_CYCLES;
    assign w_timeout        = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_we         = 1'b0;
        w_err_chk    = 1'b0;
        w_err_len    = 1'b0;
        w_err_line   = 1'b0;
        w_overrun    = 1'b0;
        // Read address stays at 0 outside a drain so entry presents buf[0] next cycle.
        w_rd_next    = '0;
        case (r_state)
            S_IDLE: begin
                if (rx_valid && !w_line_err && rx_data == SOF_BYTE) w_state_next = S_LEN;
            end
            S_LEN: begin
                if (w_line_err) begin
                    w_err_line   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (rx_valid) begin
                    if (rx_data == 8'd0 || rx_data > LEN_W'(MAX_LEN)) begin
                        w_err_len    = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_state_next = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (w_line_err) begin
                    w_err_line   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (rx_valid) begin
                    w_we = 1'b1;
                    if (w_idx_last) w_state_next = S_CHK;
                end
            end
            S_CHK: begin
                if (w_line_err) begin
                    w_err_line   = 1'b1;
                    w_state_next = S_IDLE;
                end else if (rx_valid) begin
                    if (rx_data == r_chk) begin
                        w_state_next = S_DRAIN;
                    end else begin
                        w_err_chk    = 1'b1;
                        w_state_next = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                w_overrun = rx_valid;
                w_rd_next = r_rd;
                if (w_xfer) begin
                    if (w_rd_last) begin
                        w_state_next = S_IDLE;
                        w_rd_next    = '0;
                    end else begin
                        w_rd_next = r_rd + 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
        if (w_timeout) begin
            w_err_line   = 1'b1;
            w_state_next = S_IDLE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_chk     <= '0;
            r_pkt_len <= '0;
            r_idx     <= '0;
            r_rd      <= '0;
        end else begin
            r_state <= w_state_next;
            r_rd    <= w_rd_next;
            if (r_state == S_LEN && rx_valid && !w_line_err) begin
                r_len <= rx_data;
                r_chk <= rx_data;
                r_idx <= '0;
            end
            if (w_we) begin
                r_chk <= r_chk ^ rx_data;
                r_idx <= r_idx + 1'b1;
            end
            if (r_state == S_CHK && w_state_next == S_DRAIN) begin
                r_pkt_len <= r_len;
            end
        end
    end

    uart_pkt_buf #(
        .DEPTH (MAX_LEN)
    ) u_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (r_idx),
        .i_wdata (rx_data),
        .i_raddr (w_rd_next),
        .o_rdata (w_rdata)
    );

    assign out_data  = w_rdata;
    assign out_valid = (r_state == S_DRAIN);
    assign out_last  = out_valid & w_rd_last;
    assign pkt_len   = r_pkt_len;
    assign busy      = (r_state != S_IDLE);
    assign err_chk   = w_err_chk;
    assign err_len   = w_err_len;
    assign err_line  = w_err_line;
    assign overrun   = w_overrun;

endmodule
